// File: rtl/sram_stream_reader.sv
// sram_stream_reader
//   Walks the read port of the M4 result memory from base_addr for word_count words.
//   Each word is streamed out over a valid/ready interface through a 2-entry skid FIFO.
//
// Ports
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   start                   begin a readout (sampled only while idle)
//   base_addr, word_count   first address and number of words (latched on accepted start)
//   ReadAddress1            memory read address (sampled by the memory on the clock edge)
//   ReadBus1                memory read data, valid the cycle after the address is sampled
//   out_data, out_valid,    stream output; out_data is the FIFO head
//   out_ready               downstream accept
//   busy                    readout in progress
//   done                    one-cycle pulse the cycle after the final handshake
module sram_stream_reader #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned CNT_W  = 17
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic [ADDR_W-1:0] ReadAddress1,
    input  logic [DATA_W-1:0] ReadBus1,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {StIdle, StRead, StFlush, StFinish} state_e;

    state_e            r_state;
    state_e            w_state_next;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_issued;
    logic [CNT_W-1:0]  r_accepted;
    logic              r_inflight;

    logic [DATA_W-1:0] r_fifo [2];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [1:0]        r_occ;

    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [1:0]        w_credit_used;

    assign out_valid = (r_occ != 2'd0);
    assign out_data  = r_fifo[r_rd_ptr];
    assign w_pop     = out_valid & out_ready;
    assign w_push    = r_inflight;

    // A handshake this cycle frees its slot before the next capture, so counting it as
    // released keeps the credit loop at one word per clock while never exceeding 2 entries.
    assign w_credit_used = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};

    assign w_issue = (r_state == StRead) && (r_issued != r_count) && (w_credit_used < 2'd2);

    // Present the next address only on an issue; otherwise hold the last issued address.
    assign ReadAddress1 = w_issue ? r_addr : r_addr_hold;

    assign busy = (r_state == StRead) || (r_state == StFlush);
    assign done = (r_state == StFinish);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                // An empty readout goes through FLUSH, where the accepted==count test is
                // already true, so done arrives on the same cadence as a real drain.
                if (start) begin
                    w_state_next = (word_count == '0) ? StFlush : StRead;
                end
            end
            StRead: begin
                if (r_issued == r_count) begin
                    w_state_next = StFlush;
                end
            end
            StFlush: begin
                if ((r_accepted + CNT_W'(w_pop)) == r_count) begin
                    w_state_next = StFinish;
                end
            end
            StFinish: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_addr_hold <= '0;
            r_count     <= '0;
            r_issued    <= '0;
            r_accepted  <= '0;
            r_inflight  <= 1'b0;
            r_fifo[0]   <= '0;
            r_fifo[1]   <= '0;
            r_rd_ptr    <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_occ       <= 2'd0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_issue;

            if ((r_state == StIdle) && start) begin
                r_addr     <= base_addr;
                r_count    <= word_count;
                r_issued   <= '0;
                r_accepted <= '0;
            end

            // Address arithmetic wraps naturally at 2^ADDR_W.
            if (w_issue) begin
                r_addr      <= r_addr + ADDR_W'(1);
                r_addr_hold <= r_addr;
                r_issued    <= r_issued + CNT_W'(1);
            end

            if (w_push) begin
                r_fifo[r_wr_ptr] <= ReadBus1;
                r_wr_ptr         <= ~r_wr_ptr;
            end

            if (w_pop) begin
                r_rd_ptr   <= ~r_rd_ptr;
                r_accepted <= r_accepted + CNT_W'(1);
            end

            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Self-checking bench for sram_stream_reader: table of readouts plus a reset-abort sequence.
module tb_sram_stream_reader;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = 17;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CNT_W-1:0]  word_count = '0;
    logic [ADDR_W-1:0] ReadAddress1;
    logic [DATA_W-1:0] ReadBus1;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] mem [1 << ADDR_W];
    logic [DATA_W-1:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [ADDR_W-1:0] base;
        int                count;
        int                mode;      // 0: ready high, 1: backpressure, 2: extra start while busy
        int                exp_first; // cycle of first out_valid, -1 for none
        int                exp_done;  // cycle of done, -1 means one after the last handshake
    } vec_t;

    vec_t vecs [6];

    always #5 clock = ~clock;

    // Synchronous-read memory model.
    always @(posedge clock) ReadBus1 <= mem[ReadAddress1];

    sram_stream_reader #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .base_addr    (base_addr),
        .word_count   (word_count),
        .ReadAddress1 (ReadAddress1),
        .ReadBus1     (ReadBus1),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done)
    );

    function automatic logic [DATA_W-1:0] word_at(input logic [ADDR_W-1:0] a);
        logic [31:0] w;
        w = {16'h0000, a};
        return {4{w}};
    endfunction

    function automatic logic ready_at(input int mode, input int c);
        if (mode != 1) return 1'b1;
        if (c >= 8 && c < 13) return 1'b0;
        return ((c % 4) == 0) || ((c % 4) == 3);
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run(input vec_t v);
        int                cyc;
        int                first_valid;
        int                done_cyc;
        int                n_done;
        int                last_hs;
        int                accepted;
        int                exp_done;
        logic              prev_stall;
        logic [DATA_W-1:0] prev_data;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] lead;

        first_valid = -1;
        done_cyc    = -1;
        n_done      = 0;
        last_hs     = -1;
        accepted    = 0;
        prev_stall  = 1'b0;
        prev_data   = '0;
        exp_q.delete();
        for (int i = 0; i < v.count; i++) begin
            a = v.base + ADDR_W'(i);
            exp_q.push_back(word_at(a));
        end

        @(posedge clock);
        #1;
        start      = 1'b1;
        base_addr  = v.base;
        word_count = CNT_W'(v.count);
        out_ready  = ready_at(v.mode, 0);

        for (cyc = 0; cyc < 300; cyc++) begin
            @(negedge clock);
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
            end
            if (v.count > 0 && cyc >= 1 && busy) begin
                lead = ReadAddress1 - v.base - ADDR_W'(accepted);
                n_checks++;
                if (lead > 16'd2) begin
                    n_fail++;
                    $display("FAIL read_lead: got %0d expected <= 2", lead);
                end
            end
            if (v.mode == 0 && cyc >= 1 && cyc <= v.count) begin
                a = v.base + ADDR_W'(cyc - 1);
                chk("read_addr", ReadAddress1, a);
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_word: got %0h expected none", out_data);
                end else begin
                    chk("word", out_data, exp_q.pop_front());
                end
                accepted++;
                last_hs = cyc;
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            @(posedge clock);
            #1;
            start = 1'b0;
            if (v.mode == 2 && cyc + 1 == 4) begin
                start      = 1'b1;
                base_addr  = 16'h0040;
                word_count = 17'd3;
            end
            out_ready = ready_at(v.mode, cyc + 1);
        end

        exp_done = (v.exp_done < 0) ? last_hs + 1 : v.exp_done;
        chk("done_cycle", done_cyc, exp_done);
        chk("first_valid", first_valid, v.exp_first);
        chk("done_count", n_done, 1);
        chk("accepted", accepted, v.count);
        chk("words_left", exp_q.size(), 0);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs;

        vecs[0] = '{16'h0000, 8, 0, 3, 11};
        vecs[1] = '{16'h0000, 8, 1, 3, -1};
        vecs[2] = '{16'hFFFE, 4, 0, 3, 7};
        vecs[3] = '{16'h0000, 0, 0, -1, 2};
        vecs[4] = '{16'h0000, 8, 2, 3, 11};
        vecs[5] = '{16'h0100, 1, 0, 3, 4};

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = {4{32'(i)}};

        repeat (2) @(posedge clock);
        #1;
        chk("rst_addr", ReadAddress1, 0);
        chk("rst_data", out_data, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) run(vecs[i]);

        // Abort a readout after three words with an asynchronous reset.
        @(posedge clock);
        #1;
        start      = 1'b1;
        base_addr  = 16'h0000;
        word_count = 17'd8;
        out_ready  = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        hs    = 0;
        for (int c = 0; c < 50 && hs < 3; c++) begin
            @(negedge clock);
            if (out_valid && out_ready) hs++;
        end
        chk("pre_reset_hs", hs, 3);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_addr", ReadAddress1, 0);
        chk("abort_data", out_data, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            chk("post_abort_done", done, 0);
            chk("post_abort_valid", out_valid, 0);
        end
        run('{16'h0010, 2, 0, 3, 5});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
